// File: rtl/alu_cdb_queue.sv
// Result queue between an ALU and its common-data-bus port: strict FIFO with a sticky drop flag.
// Optional empty-queue bypass enabled by defining ALU_CDB_QUEUE_BYPASS_EN.
module alu_cdb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [100:0]  in_data,
   output logic          in_ready,
   output logic          cdb_req,
   input  logic          cdb_granted,
   output logic [100:0]  cdb_dout,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [100:0]  r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic w_full;
   logic w_empty;
   logic w_byp;
   logic w_byp_taken;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);

`ifdef ALU_CDB_QUEUE_BYPASS_EN
   assign w_byp = w_empty & in_valid;
`else
   assign w_byp = 1'b0;
`endif

   // A bypassed result granted in the same cycle goes straight to the bus and is never stored.
   assign w_byp_taken = w_byp & cdb_granted;
   assign w_push      = in_valid & ~w_full & ~w_byp_taken;
   assign w_pop       = ~w_empty & cdb_granted;

   assign in_ready = ~w_full;
   assign cdb_req  = ~w_empty | w_byp;
   assign count    = r_count;
   assign overflow = r_overflow;

   always_comb begin
      cdb_dout = '0;
      if (!w_empty) begin
         cdb_dout = r_mem[r_head];
      end else if (w_byp) begin
         cdb_dout = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (in_valid && w_full) r_overflow <= 1'b1;
      end
   end

   // Storage is left uninitialised by reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_tail] <= in_data;
   end

endmodule

// File: tb/tb_alu_cdb_queue.sv
// Directed bench for alu_cdb_queue: a queue scoreboard predicts bus output, occupancy and overflow.
// Follows ALU_CDB_QUEUE_BYPASS_EN the same way the design does.
module tb_alu_cdb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [100:0]  in_data = '0;
   logic          in_ready;
   logic          cdb_req;
   logic          cdb_granted = 1'b0;
   logic [100:0]  cdb_dout;
   logic [AW:0]   count;
   logic          overflow;

   int checks = 0;
   int failures = 0;
   logic [100:0] sb[$];
   logic         mover = 1'b0;

   alu_cdb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .cdb_req(cdb_req), .cdb_granted(cdb_granted),
      .cdb_dout(cdb_dout), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [100:0] rnd101();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[100:0];
   endfunction

   // One clock cycle: drive inputs, check combinational outputs, advance the model, check state.
   task automatic cyc(input logic v, input logic [100:0] d, input logic g, input string tag);
      logic         byp;
      logic         exp_req;
      logic [100:0] exp_dout;
      int           n;
      @(negedge clk);
      in_valid = v; in_data = d; cdb_granted = g;
      #1;
      n = sb.size();
      byp = 1'b0;
`ifdef ALU_CDB_QUEUE_BYPASS_EN
      byp = (n == 0) && v;
`endif
      exp_req  = (n != 0) || byp;
      exp_dout = (n != 0) ? sb[0] : (byp ? d : '0);
      chk({tag, ".in_ready"}, in_ready, n != DEPTH);
      chk({tag, ".cdb_req"}, cdb_req, exp_req);
      chk({tag, ".cdb_dout"}, cdb_dout, exp_dout);
      if (v && n == DEPTH) mover = 1'b1;
      if (n != 0 && g) void'(sb.pop_front());
      if (v && n != DEPTH && !(byp && g)) sb.push_back(d);
      @(posedge clk);
      #1;
      chk({tag, ".count"}, count, sb.size());
      chk({tag, ".overflow"}, overflow, mover);
   endtask

   task automatic rst_cyc(input logic v, input logic g, input string tag);
      @(negedge clk);
      rst = 1'b1; in_valid = v; cdb_granted = g; in_data = rnd101();
      @(posedge clk);
      #1;
      sb.delete();
      mover = 1'b0;
      chk({tag, ".count"}, count, 0);
      chk({tag, ".overflow"}, overflow, 0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; cdb_granted = 1'b0;
      #1;
      chk({tag, ".in_ready"}, in_ready, 1);
      chk({tag, ".cdb_req"}, cdb_req, 0);
      chk({tag, ".cdb_dout"}, cdb_dout, 0);
   endtask

   initial begin
      rst_cyc(1'b0, 1'b0, "reset");
      cyc(1'b0, '0, 1'b0, "idle");

      // Three pushes with no grant, then drain in order.
      cyc(1'b1, 101'h1, 1'b0, "pushA");
      cyc(1'b1, 101'h2, 1'b0, "pushB");
      cyc(1'b1, 101'h3, 1'b0, "pushC");
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, "drain3");
      cyc(1'b0, '0, 1'b0, "empty");

      // Fill, overflow with D, drain.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd101(), 1'b0, "fill");
      cyc(1'b1, 101'hD, 1'b0, "dropD");
      cyc(1'b0, '0, 1'b0, "sticky");
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, "drainD");
      cyc(1'b0, '0, 1'b0, "emptyD");

      // Full with push and grant together, then push+pop at occupancy 2 across wraps.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd101(), 1'b0, "fill2");
      cyc(1'b1, rnd101(), 1'b1, "fullpp");
      cyc(1'b0, '0, 1'b1, "to2");
      for (int i = 0; i < 10; i++) cyc(1'b1, rnd101(), 1'b1, "pp2");
      cyc(1'b1, rnd101(), 1'b0, "to3");
      cyc(1'b1, rnd101(), 1'b1, "pp3");
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, "drain31");
      cyc(1'b1, rnd101(), 1'b0, "to1");
      cyc(1'b1, rnd101(), 1'b1, "pp1");
      cyc(1'b0, '0, 1'b1, "drain1");

      // Grant while idle is ignored.
      rst_cyc(1'b0, 1'b0, "reset2");
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0, 1'b1, "ghost");
         cyc(1'b0, '0, 1'b0, "ghostoff");
      end

      // Reset mid-operation with push and grant asserted.
      for (int i = 0; i < 3; i++) cyc(1'b1, rnd101(), 1'b0, "pre_rst");
      rst_cyc(1'b1, 1'b1, "midrst");
      cyc(1'b0, '0, 1'b0, "post_rst");

      // Empty queue, push E with grant in the same cycle.
      cyc(1'b1, 101'h1F, 1'b1, "pushE");
      for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, "drainE");

      // Random traffic.
      for (int i = 0; i < 40; i++)
         cyc(1'($urandom_range(0, 1)), rnd101(), 1'($urandom_range(0, 1)), "rand");
      for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, 1'b1, "final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
